// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : md_pkg
//  Description : Shared operation encodings, default latencies and small
//                op-decoding helpers for the multiply/divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package md_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // True for the two multiply flavours
    function automatic logic is_mult(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    // True for the two divide flavours
    function automatic logic is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage : md_pkg
`default_nettype wire

// File: rtl/md_arith.sv
`default_nettype none
// ============================================================================
//  Module      : md_arith
//  Description : Combinational 64-bit {HI,LO} result for mult/multu/div/divu.
//                Division yields {remainder, quotient}; a zero divisor yields
//                zero (the controller discards it anyway).
//  Revision    : 1.0 - initial release
// ============================================================================
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] result_o
);

    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic               w_div_ovf;

    assign w_prod_s  = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
    assign w_prod_u  = {32'd0, a_i} * {32'd0, b_i};
    // Most-negative / -1 overflows the signed quotient; pin it explicitly
    assign w_div_ovf = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);

    // Select the result for the requested operation
    always_comb begin
        result_o = '0;
        case (op_i)
            OP_MULT:  result_o = w_prod_s;
            OP_MULTU: result_o = w_prod_u;
            OP_DIV: begin
                if (w_div_ovf) begin
                    result_o = {32'h0000_0000, 32'h8000_0000};
                end else if (b_i != 32'd0) begin
                    result_o = {$signed(a_i) % $signed(b_i), $signed(a_i) / $signed(b_i)};
                end
            end
            OP_DIVU: begin
                if (b_i != 32'd0) begin
                    result_o = {a_i % b_i, a_i / b_i};
                end
            end
            default: result_o = '0;
        endcase
    end

endmodule : md_arith
`default_nettype wire

// File: rtl/md_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : md_ctrl
//  Description : Multi-cycle multiply/divide controller owning HI/LO. The
//                result is captured at start and committed when the busy
//                window expires; also produces the pipeline stall request.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] CNT_MULT = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] CNT_DIV  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]    state_q,  state_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic [63:0]   res_q,    res_d;
    logic          commit_q, commit_d;
    logic [31:0]   hi_q,     hi_d;
    logic [31:0]   lo_q,     lo_d;
    logic [63:0]   arith_res;

    md_arith u_arith (
        .op_i     (op),
        .a_i      (A),
        .b_i      (B),
        .result_o (arith_res)
    );

    // Next-state: launch ops from IDLE, count down in RUN, commit on the last cycle
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        commit_d = commit_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_mult(op)) begin
                        res_d    = arith_res;
                        commit_d = 1'b1;
                        cnt_d    = CNT_MULT;
                        state_d  = ST_RUN;
                    end else if (is_div(op)) begin
                        res_d    = arith_res;
                        // Divide by zero still occupies the unit but leaves HI/LO alone
                        commit_d = (B != 32'd0);
                        cnt_d    = CNT_DIV;
                        state_d  = ST_RUN;
                    end else if (op == OP_MTHI) begin
                        hi_d = A;
                    end else if (op == OP_MTLO) begin
                        lo_d = A;
                    end
                end
            end
            ST_RUN: begin
                // start is not accepted here; the stall keeps new md ops out of E
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q <= CNT_ONE) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (commit_q) begin
                        hi_d = res_q[63:32];
                        lo_d = res_q[31:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            res_q    <= '0;
            commit_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            commit_q <= commit_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // Stall F/D while a D-stage md instruction would collide with an active or starting op
    always_comb begin
        busy     = (state_q == ST_RUN);
        stall_md = reset_n && md_use_D && ((start && (is_mult(op) || is_div(op))) || busy);
        HI       = hi_q;
        LO       = lo_q;
    end

endmodule : md_ctrl
`default_nettype wire

// File: tb/tb_md_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_md_ctrl
//  Description : Directed self-checking bench for md_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_md_ctrl;

    localparam logic [2:0] C_MULT  = 3'b000;
    localparam logic [2:0] C_MULTU = 3'b001;
    localparam logic [2:0] C_DIV   = 3'b010;
    localparam logic [2:0] C_DIVU  = 3'b011;
    localparam logic [2:0] C_MTHI  = 3'b100;
    localparam logic [2:0] C_MTLO  = 3'b101;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        md_use_D;
    logic        busy;
    logic        stall_md;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks = 0;
    int n_pass   = 0;

    md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .op       (op),
        .A        (A),
        .B        (B),
        .md_use_D (md_use_D),
        .busy     (busy),
        .stall_md (stall_md),
        .HI       (HI),
        .LO       (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A new start while the unit is running must never be issued
    always @(posedge clk) begin
        if (reset_n && start && busy) begin
            n_checks++;
            $display("FAIL start_while_busy: start=1 busy=1, required no start while busy");
        end
    end

    // Launch an op and count busy cycles; checks count, then HI/LO
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cycles;
        logic [31:0] hi_before;
        @(negedge clk);
        hi_before = HI;
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (HI !== hi_before) $display("FAIL %s_hi_early: got %h required %h", name, HI, hi_before);
        else n_pass++;
        cycles = 0;
        while (busy && cycles < 40) begin
            cycles++;
            @(negedge clk);
        end
        n_checks++;
        if (cycles !== n) $display("FAIL %s_busy_len: got %0d required %0d", name, cycles, n);
        else n_pass++;
        n_checks++;
        if (HI !== exp_hi) $display("FAIL %s_hi: got %h required %h", name, HI, exp_hi);
        else n_pass++;
        n_checks++;
        if (LO !== exp_lo) $display("FAIL %s_lo: got %h required %h", name, LO, exp_lo);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b1; op = C_MULT; A = 32'd7; B = 32'd9; md_use_D = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (stall_md !== 1'b0) $display("FAIL reset_stall: got %b required 0", stall_md);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy);
        else n_pass++;
        n_checks++;
        if ({HI, LO} !== 64'd0) $display("FAIL reset_hilo: got %h required 0", {HI, LO});
        else n_pass++;
        start = 1'b0; md_use_D = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_release_busy: got %b required 0", busy);
        else n_pass++;
    endtask

    task automatic test_mult();
        run_op("mult",  C_MULT,  32'hFFFF_FFFE, 32'd3,         5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
    endtask

    task automatic test_div();
        run_op("div_neg",  C_DIV,  32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_b0",  C_DIVU, 32'd1234,      32'd0,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_ovf",  C_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
        run_op("divu",     C_DIVU, 32'd100,       32'd7,         10, 32'd2,         32'd14);
        run_op("div_negb", C_DIV,  32'd7,         32'hFFFF_FFFE, 10, 32'd1,         32'hFFFF_FFFD);
        run_op("divu_big", C_DIVU, 32'hFFFF_FFF9, 32'd2,         10, 32'd1,         32'h7FFF_FFFC);
    endtask

    task automatic test_stall();
        @(negedge clk);
        md_use_D = 1'b1; start = 1'b1; op = C_MULT; A = 32'd2; B = 32'd3;
        #1;
        n_checks++;
        if (stall_md !== 1'b1) $display("FAIL stall_start: got %b required 1", stall_md);
        else n_pass++;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (stall_md !== 1'b1) $display("FAIL stall_busy%0d: got %b required 1", i, stall_md);
            else n_pass++;
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (stall_md !== 1'b0) $display("FAIL stall_after: got %b required 0", stall_md);
        else n_pass++;
        n_checks++;
        if ({HI, LO} !== {32'd0, 32'd6}) $display("FAIL stall_result: got %h required %h", {HI, LO}, {32'd0, 32'd6});
        else n_pass++;
        // No stall from an md start when D does not use the unit
        md_use_D = 1'b0; start = 1'b1; op = C_DIV; A = 32'd1; B = 32'd1;
        #1;
        n_checks++;
        if (stall_md !== 1'b0) $display("FAIL stall_noD: got %b required 0", stall_md);
        else n_pass++;
        // mthi start does not stall
        md_use_D = 1'b1; op = C_MTHI;
        #1;
        n_checks++;
        if (stall_md !== 1'b0) $display("FAIL stall_mthi: got %b required 0", stall_md);
        else n_pass++;
        start = 1'b0; md_use_D = 1'b0;
    endtask

    task automatic test_mthi_mtlo();
        @(negedge clk);
        start = 1'b1; op = C_MTHI; A = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (HI !== 32'h1234_5678) $display("FAIL mthi_hi: got %h required 12345678", HI);
        else n_pass++;
        n_checks++;
        if (LO !== 32'd6) $display("FAIL mthi_lo: got %h required 00000006", LO);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL mthi_busy: got %b required 0", busy);
        else n_pass++;
        start = 1'b1; op = C_MTLO; A = 32'hCAFE_F00D;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({HI, LO} !== {32'h1234_5678, 32'hCAFE_F00D})
            $display("FAIL mtlo: got %h required 12345678cafef00d", {HI, LO});
        else n_pass++;
    endtask

    task automatic test_illegal_op();
        @(negedge clk);
        start = 1'b1; op = 3'b110; A = 32'h5555_5555; B = 32'd3;
        @(negedge clk);
        op = 3'b111;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL illegal_busy: got %b required 0", busy);
        else n_pass++;
        n_checks++;
        if ({HI, LO} !== {32'h1234_5678, 32'hCAFE_F00D})
            $display("FAIL illegal_hilo: got %h required 12345678cafef00d", {HI, LO});
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        run_op("b2b_mult", C_MULT, 32'd10, 32'hFFFF_FFFD, 5, 32'hFFFF_FFFF, 32'hFFFF_FFE2);
        run_op("b2b_div",  C_DIV,  32'd20, 32'd6,         10, 32'd2,        32'd3);
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        start = 1'b1; op = C_DIV; A = 32'd50; B = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL midrst_busy_before: got %b required 1", busy);
        else n_pass++;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL midrst_busy: got %b required 0", busy);
        else n_pass++;
        n_checks++;
        if ({HI, LO} !== 64'd0) $display("FAIL midrst_hilo: got %h required 0", {HI, LO});
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL midrst_idle: got %b required 0", busy);
        else n_pass++;
        n_checks++;
        if ({HI, LO} !== 64'd0) $display("FAIL midrst_hilo_after: got %h required 0", {HI, LO});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_stall();
        test_mthi_mtlo();
        test_illegal_op();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_md_ctrl
`default_nettype wire

// File: doc/md_ctrl.md
MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5, busy length of mult/multu.
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10, busy length of div/divu.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port start  input  1  E-stage md instruction valid this cycle.
REQ-006 The block SHALL have port op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo.
REQ-007 The block SHALL have port A  input  32  rs operand (forwarded E-stage value).
REQ-008 The block SHALL have port B  input  32  rt operand (forwarded E-stage value).
REQ-009 The block SHALL have port md_use_D  input  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-010 The block SHALL have port busy  output  1  multi-cycle operation in progress.
REQ-011 The block SHALL have port stall_md  output  1  freeze F/D and insert bubble into E.
REQ-012 The block SHALL have port HI  output  32  architectural HI register.
REQ-013 The block SHALL have port LO  output  32  architectural LO register.

Function
REQ-014 States SHALL be IDLE and RUN; a cycle counter (width to hold max(MULT_CYCLES, DIV_CYCLES)) exists in RUN.
REQ-015 IDLE + start + op in {mult,multu}: latch 64-bit result, counter := MULT_CYCLES, go RUN.
REQ-016 IDLE + start + op in {div,divu}: latch result, counter := DIV_CYCLES, go RUN.
REQ-017 RUN: counter decrements each cycle; busy=1 for exactly N cycles starting the cycle after start.
REQ-018 HI/LO SHALL update on the edge ending the Nth busy cycle; busy falls in the same edge; state returns to IDLE.
REQ-019 mthi/mtlo with start: HI (resp. LO) := A on the next edge; no busy; other register unchanged.
REQ-020 mult: signed 32x32->64; multu: unsigned; HI = product[63:32], LO = product[31:0].
REQ-021 div/divu: LO = quotient truncated toward zero, HI = remainder with sign of dividend (A).
REQ-022 Divide by zero (B==0): operation still runs DIV_CYCLES busy cycles; HI and LO SHALL remain unchanged.
REQ-023 div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0x00000000.
REQ-024 stall_md SHALL equal md_use_D && (start_is_mult_or_div || busy), combinational.
REQ-025 start while RUN SHALL be ignored (illegal under REQ-024); bench asserts it never occurs.
REQ-026 op values 110/111 with start SHALL be ignored; no state change.
REQ-027 mfhi/mflo read HI/LO directly; a read in the edge that updates HI/LO sees the old value (stalled anyway).

Reset
REQ-028 reset_n low SHALL asynchronously force state IDLE, counter 0, busy 0, HI 0, LO 0, pending result 0.
REQ-029 Reset asserted mid-RUN SHALL abort the operation; HI/LO keep reset value 0 after release.
REQ-030 stall_md SHALL be 0 during reset regardless of md_use_D.

Structure
REQ-031 Package md_pkg SHALL hold the op encodings and default MULT_CYCLES/DIV_CYCLES constants.
REQ-032 Sub-module md_arith SHALL compute the 64-bit {HI,LO} result combinationally from op, A, B.
REQ-033 The hazard unit SHALL OR stall_md into its existing pause output; md_ctrl does not see instruction words.

Verification
REQ-034 mult A=0xFFFFFFFE, B=3 -> busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-035 multu A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
REQ-036 div A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu B=0 -> HI/LO unchanged.
REQ-037 md_use_D held 1 during mult -> stall_md=1 in start cycle and all 5 busy cycles, 0 the cycle after.
REQ-038 mthi A=0x12345678 -> HI=0x12345678 next edge, busy stays 0, LO unchanged.
REQ-039 reset_n pulsed low at busy cycle 3 of div -> busy=0, HI=LO=0 immediately, IDLE after release.
